// File: rtl/int_alu_exe_if.sv
// Bundle of the issue-side and intCDB-side signals of the integer ALU execute stage.
//
//   slave  : the execute stage. It takes the issued instruction, flush and grant,
//            and drives issue_ready and the intCDB head-entry outputs.
//   master : the environment (reservation station, flush source, CDB arbiter).
//
// Optional feature macro: ALU_OVERFLOW_EXC_EN. When it is defined, the interface
// also carries intCDB_exc.
interface int_alu_exe_if #(
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32
);
  // Issue side
  logic                 issue_valid;
  logic                 issue_ready;
  logic [3:0]           alu_op;
  logic [DATA_W-1:0]    operand_a;
  logic [DATA_W-1:0]    operand_b;
  logic [DATA_W-1:0]    imm_operand;
  logic                 use_imm;
  logic [DATA_W-1:0]    pc;
  logic [ROB_IDX_W-1:0] dest_ROB_index;
  logic                 flush;

  // Common data bus side
  logic                 intCDB_grant;
  logic                 intCDB_req;
  logic [ROB_IDX_W-1:0] intCDB_ROB_index;
  logic [DATA_W-1:0]    intCDB_data;
`ifdef ALU_OVERFLOW_EXC_EN
  logic                 intCDB_exc;
`endif

  modport slave (
    input  issue_valid, alu_op, operand_a, operand_b, imm_operand, use_imm, pc,
           dest_ROB_index, flush, intCDB_grant,
    output issue_ready, intCDB_req, intCDB_ROB_index, intCDB_data
`ifdef ALU_OVERFLOW_EXC_EN
    , output intCDB_exc
`endif
  );

  modport master (
    output issue_valid, alu_op, operand_a, operand_b, imm_operand, use_imm, pc,
           dest_ROB_index, flush, intCDB_grant,
    input  issue_ready, intCDB_req, intCDB_ROB_index, intCDB_data
`ifdef ALU_OVERFLOW_EXC_EN
    , input intCDB_exc
`endif
  );
endinterface

// File: rtl/int_alu_exe.sv
// Integer ALU execute stage.
//
// Accepts one instruction per cycle from the ALU reservation station, computes
// its result in the same cycle and writes {ROB index, data[, exc]} into a
// 2-entry result FIFO. The FIFO head is presented on the intCDB and is popped
// when the arbiter grants the bus. A flush empties the FIFO and drops any
// same-cycle issue or grant.
//
// Ports:
//   clk  : core clock, everything is on the rising edge
//   rst  : synchronous active-high reset
//   bus  : int_alu_exe_if.slave (issue handshake, operands, flush, intCDB)
//
// Optional feature macro: ALU_OVERFLOW_EXC_EN. When it is defined, ADD/SUB
// signed overflow is recorded per entry and shown on intCDB_exc. When it is
// undefined, overflow wraps silently and no exc storage exists.
module int_alu_exe #(
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  int_alu_exe_if.slave  bus
);

  localparam int SH_W = $clog2(DATA_W);

  // Operand selection and the arithmetic results
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_result;
  logic [SH_W-1:0]   w_shamt;

  assign w_a     = bus.operand_a;
  assign w_b     = bus.use_imm ? bus.imm_operand : bus.operand_b;
  assign w_sum   = w_a + w_b;
  assign w_diff  = w_a - w_b;
  assign w_shamt = w_b[SH_W-1:0];

  always_comb begin
    w_result = '0;
    case (bus.alu_op)
      4'd0:  w_result = w_sum;
      4'd1:  w_result = w_diff;
      4'd2:  w_result = w_a & w_b;
      4'd3:  w_result = w_a | w_b;
      4'd4:  w_result = w_a ^ w_b;
      4'd5:  w_result = ~(w_a | w_b);
      4'd6:  w_result = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      4'd7:  w_result = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
      4'd8:  w_result = w_a << w_shamt;
      4'd9:  w_result = w_a >> w_shamt;
      4'd10: w_result = $unsigned($signed(w_a) >>> w_shamt);
      4'd11: w_result = {w_b[15:0], {(DATA_W-16){1'b0}}};
      4'd12: w_result = bus.pc + DATA_W'(8);
      default: w_result = '0;  // reserved opcodes produce zero
    endcase
  end

`ifdef ALU_OVERFLOW_EXC_EN
  // Signed overflow: the effective operands share a sign and the result's sign
  // differs from it. SUB uses ~b, so "same sign" becomes a and b of opposite sign.
  logic w_ovf;
  always_comb begin
    w_ovf = 1'b0;
    case (bus.alu_op)
      4'd0: w_ovf = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_sum[DATA_W-1]  != w_a[DATA_W-1]);
      4'd1: w_ovf = (w_a[DATA_W-1] != w_b[DATA_W-1]) && (w_diff[DATA_W-1] != w_a[DATA_W-1]);
      default: w_ovf = 1'b0;
    endcase
  end
`endif

  // Result FIFO state
  logic [1:0]           r_count;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [ROB_IDX_W-1:0] r_rob  [2];
  logic [DATA_W-1:0]    r_data [2];
`ifdef ALU_OVERFLOW_EXC_EN
  logic                 r_exc  [2];
`endif

  logic w_req;
  logic w_push;
  logic w_pop;

  // issue_ready depends only on the count; a pop in the same cycle does not
  // open a slot until the next cycle.
  assign bus.issue_ready = !rst && (r_count != 2'd2);
  assign w_req           = (r_count != 2'd0);

  // A flush suppresses both the same-cycle push and the same-cycle pop.
  assign w_push = bus.issue_valid && bus.issue_ready && !bus.flush;
  assign w_pop  = w_req && bus.intCDB_grant && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset: it is only visible while the count covers it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rob[r_wr_ptr]  <= bus.dest_ROB_index;
      r_data[r_wr_ptr] <= w_result;
`ifdef ALU_OVERFLOW_EXC_EN
      r_exc[r_wr_ptr]  <= w_ovf;
`endif
    end
  end

  // Head entry on the bus, forced to zero while the FIFO is empty
  assign bus.intCDB_req       = w_req;
  assign bus.intCDB_ROB_index = w_req ? r_rob[r_rd_ptr]  : '0;
  assign bus.intCDB_data      = w_req ? r_data[r_rd_ptr] : '0;
`ifdef ALU_OVERFLOW_EXC_EN
  assign bus.intCDB_exc       = w_req ? r_exc[r_rd_ptr]  : 1'b0;
`endif

endmodule

// File: tb/tb_int_alu_exe.sv
module tb_int_alu_exe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int_alu_exe_if #(.ROB_IDX_W(4), .DATA_W(32)) bus ();

  int_alu_exe #(.ROB_IDX_W(4), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] data;
    logic        exc;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        ui;
    logic [31:0] pc;
    logic [3:0]  rob;
    logic [31:0] d;
    logic        e;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[18];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_data;
  logic        cur_exc;
  bit          accepted;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // One clock: compare outputs at the falling edge against the scoreboard,
  // then account for the push/pop that the rising edge will perform.
  task automatic cycle();
    bit rdy_exp;
    exp_t h;
    @(negedge clk);
    accepted = 0;
    rdy_exp  = !rst && (sb.size() < 2);
    check("issue_ready", bus.issue_ready, rdy_exp);
    check("intCDB_req", bus.intCDB_req, sb.size() != 0);
    if (sb.size() == 0) begin
      check("idle_index", bus.intCDB_ROB_index, 0);
      check("idle_data", bus.intCDB_data, 0);
`ifdef ALU_OVERFLOW_EXC_EN
      check("idle_exc", bus.intCDB_exc, 0);
`endif
    end else begin
      h = sb[0];
      check("head_index", bus.intCDB_ROB_index, h.rob);
      check("head_data", bus.intCDB_data, h.data);
`ifdef ALU_OVERFLOW_EXC_EN
      check("head_exc", bus.intCDB_exc, h.exc);
`endif
    end
    if (rst || bus.flush) begin
      sb.delete();
    end else begin
      if (bus.intCDB_grant && sb.size() != 0) void'(sb.pop_front());
      if (bus.issue_valid && rdy_exp) begin
        sb.push_back('{rob: bus.dest_ROB_index, data: cur_data, exc: cur_exc});
        accepted = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic ui, input logic [31:0] pc,
                          input logic [3:0] rob, input logic [31:0] d, input logic e);
    bus.alu_op         = op;
    bus.operand_a      = a;
    bus.operand_b      = b;
    bus.imm_operand    = imm;
    bus.use_imm        = ui;
    bus.pc             = pc;
    bus.dest_ROB_index = rob;
    bus.issue_valid    = 1'b1;
    cur_data           = d;
    cur_exc            = e;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (accepted) break;
    end
    if (!accepted) timeout_fail("issue_accept");
  endtask

  task automatic drain();
    bus.issue_valid  = 1'b0;
    bus.intCDB_grant = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
    if (sb.size() != 0) timeout_fail("drain");
    cycle();
  endtask

  initial begin
    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h0, 1'b0, 32'h0,   4'd1,  32'h80000000, 1'b1};
    vecs[1]  = '{4'd1,  32'h80000000, 32'h00000001, 32'h0, 1'b0, 32'h0,   4'd2,  32'h7FFFFFFF, 1'b1};
    vecs[2]  = '{4'd0,  32'h00000001, 32'h00000001, 32'h0, 1'b0, 32'h0,   4'd3,  32'h00000002, 1'b0};
    vecs[3]  = '{4'd1,  32'h00000005, 32'h00000007, 32'h0, 1'b0, 32'h0,   4'd4,  32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{4'd2,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h0, 1'b0, 32'h0,   4'd5,  32'h00F0F000, 1'b0};
    vecs[5]  = '{4'd3,  32'hF0F00000, 32'h0000000F, 32'h0, 1'b0, 32'h0,   4'd6,  32'hF0F0000F, 1'b0};
    vecs[6]  = '{4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 1'b0, 32'h0,   4'd7,  32'hF0F00F0F, 1'b0};
    vecs[7]  = '{4'd5,  32'hF0F00000, 32'h0000000F, 32'h0, 1'b0, 32'h0,   4'd8,  32'h0F0FFFF0, 1'b0};
    vecs[8]  = '{4'd6,  32'h80000000, 32'h00000001, 32'h0, 1'b0, 32'h0,   4'd9,  32'h00000001, 1'b0};
    vecs[9]  = '{4'd7,  32'h80000000, 32'h00000001, 32'h0, 1'b0, 32'h0,   4'd10, 32'h00000000, 1'b0};
    vecs[10] = '{4'd8,  32'h00000001, 32'h00000024, 32'h0, 1'b0, 32'h0,   4'd11, 32'h00000010, 1'b0};
    vecs[11] = '{4'd9,  32'h80000000, 32'h00000004, 32'h0, 1'b0, 32'h0,   4'd12, 32'h08000000, 1'b0};
    vecs[12] = '{4'd10, 32'h80000000, 32'h00000004, 32'h0, 1'b0, 32'h0,   4'd13, 32'hF8000000, 1'b0};
    vecs[13] = '{4'd11, 32'h00000000, 32'h0000FFFF, 32'h1234, 1'b1, 32'h0, 4'd14, 32'h12340000, 1'b0};
    vecs[14] = '{4'd12, 32'h00000000, 32'h00000000, 32'h0, 1'b0, 32'h100, 4'd15, 32'h00000108, 1'b0};
    vecs[15] = '{4'd13, 32'h00000005, 32'h00000006, 32'h0, 1'b0, 32'h0,   4'd0,  32'h00000000, 1'b0};
    vecs[16] = '{4'd0,  32'h0000000A, 32'h00000063, 32'hFFFFFFFF, 1'b1, 32'h0, 4'd1, 32'h00000009, 1'b0};
    vecs[17] = '{4'd1,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0,   4'd2,  32'h80000000, 1'b1};

    bus.issue_valid    = 1'b0;
    bus.alu_op         = 4'd0;
    bus.operand_a      = '0;
    bus.operand_b      = '0;
    bus.imm_operand    = '0;
    bus.use_imm        = 1'b0;
    bus.pc             = '0;
    bus.dest_ROB_index = '0;
    bus.flush          = 1'b0;
    bus.intCDB_grant   = 1'b0;
    cur_data           = '0;
    cur_exc            = 1'b0;

    // Reset: ready held low during rst, outputs zero, ready high once rst falls
    @(posedge clk);
    #1;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Single ADD with grant held high: broadcast the cycle after issue, then idle
    bus.intCDB_grant = 1'b1;
    issue_op(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 32'd0, 4'd3, 32'd12, 1'b0);
    bus.issue_valid = 1'b0;
    cycle();
    cycle();

    // Backpressure: two accepts fill the FIFO, the third op is held
    bus.intCDB_grant = 1'b0;
    issue_op(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 32'd0, 4'd1, 32'd2, 1'b0);
    issue_op(4'd1, 32'd10, 32'd3, 32'd0, 1'b0, 32'd0, 4'd2, 32'd7, 1'b0);
    bus.alu_op         = 4'd4;
    bus.operand_a      = 32'hFF00FF00;
    bus.operand_b      = 32'h0F0F0F0F;
    bus.dest_ROB_index = 4'd3;
    cur_data           = 32'hF00FF00F;
    cur_exc            = 1'b0;
    repeat (3) cycle();
    check("third_held", accepted, 0);
    bus.intCDB_grant = 1'b1;
    for (int i = 0; i < 5 && !accepted; i++) cycle();
    if (!accepted) timeout_fail("third_accept");
    drain();

    // Table sweep, back-to-back with continuous grant
    bus.intCDB_grant = 1'b1;
    foreach (vecs[i])
      issue_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].ui, vecs[i].pc,
               vecs[i].rob, vecs[i].d, vecs[i].e);
    drain();

    // Flush with two buffered entries plus a same-cycle issue and grant
    bus.intCDB_grant = 1'b0;
    issue_op(4'd0, 32'd20, 32'd1, 32'd0, 1'b0, 32'd0, 4'd5, 32'd21, 1'b0);
    issue_op(4'd0, 32'd30, 32'd1, 32'd0, 1'b0, 32'd0, 4'd6, 32'd31, 1'b0);
    bus.dest_ROB_index = 4'd7;
    bus.intCDB_grant   = 1'b1;
    bus.flush          = 1'b1;
    cycle();
    bus.flush        = 1'b0;
    bus.issue_valid  = 1'b0;
    bus.intCDB_grant = 1'b0;
    cycle();
    bus.intCDB_grant = 1'b1;
    repeat (2) cycle();

    // Simultaneous push and pop: ROB 4 granted while ROB 9 issues
    bus.intCDB_grant = 1'b0;
    issue_op(4'd3, 32'h00000040, 32'h00000004, 32'd0, 1'b0, 32'd0, 4'd4, 32'h00000044, 1'b0);
    bus.intCDB_grant = 1'b1;
    issue_op(4'd8, 32'h00000003, 32'h00000002, 32'd0, 1'b0, 32'd0, 4'd9, 32'h0000000C, 1'b0);
    bus.issue_valid  = 1'b0;
    bus.intCDB_grant = 1'b0;
    cycle();
    check("sim_pushpop_count", sb.size(), 1);
    drain();

    // Reset in the middle of operation
    bus.intCDB_grant = 1'b0;
    issue_op(4'd0, 32'd2, 32'd2, 32'd0, 1'b0, 32'd0, 4'd10, 32'd4, 1'b0);
    bus.issue_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (t=%0t)", $time);
    $fatal(1);
  end
endmodule

// File: doc/int_alu_exe.md
# int_alu_exe

Integer ALU execute stage of the out-of-order core, directly downstream of the ALU reservation station. Accepts one ready instruction per cycle (operands already resolved, destination ROB index attached), computes the result in one cycle, and holds it in a 2-entry result buffer. The buffer head then requests the integer common data bus (intCDB) and waits for a grant. A branch-mispredict flush discards all in-flight results.

## Interface
Parameters:
- ROB_IDX_W, 4, ROB index width (16-entry ROB)
- DATA_W, 32, datapath width

Ports:
- clk  in  1  core clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  reservation station presents an instruction
- issue_ready  out  1  stage can accept this cycle
- alu_op  in  4  operation code (see Operation)
- operand_a  in  32  source A
- operand_b  in  32  source B
- imm_operand  in  32  sign/zero-extended immediate
- use_imm  in  1  1: B-side = imm_operand, 0: B-side = operand_b
- pc  in  32  instruction PC
- dest_ROB_index  in  4  destination ROB entry
- flush  in  1  mispredict flush; kills all buffered and same-cycle work
- intCDB_grant  in  1  arbiter grants intCDB to this unit this cycle
- intCDB_req  out  1  head entry valid, requesting bus
- intCDB_ROB_index  out  4  head entry ROB index
- intCDB_data  out  32  head entry result
- intCDB_exc  out  1  head entry overflow flag (present only with ALU_OVERFLOW_EXC_EN)

## Operation
- B-side operand: b = use_imm ? imm_operand : operand_b.
- Opcodes:
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOR
  - 6 SLT: signed a<b, result 1/0
  - 7 SLTU: unsigned compare
  - 8 SLL: a<<b[4:0]
  - 9 SRL: logical right shift
  - 10 SRA: arithmetic right shift
  - 11 LUI: {b[15:0],16'h0}
  - 12 LINK: pc+8
  - 13-15 reserved: result 0
- All arithmetic is mod 2^32; carry-out is discarded.
- Issue handshake: transfer occurs when issue_valid && issue_ready. The computed result {ROB index, data, exc} is written into the result buffer at that clock edge.
- Result buffer: 2-entry FIFO, with a count of 0..2.
  - issue_ready = !rst && count<2. This is a combinational function of count only; there is no same-cycle pass-through from pop.
- Broadcast:
  - intCDB_req = count!=0.
  - intCDB_* outputs show the head entry.
  - When the FIFO is empty: index 0, data 0, exc 0.
  - The head is popped at the edge where intCDB_req && intCDB_grant.
- Simultaneous push and pop: count unchanged, with FIFO order preserved.
- count==2: issue_ready=0. A pop in that cycle frees a slot for the next cycle only.
- flush (has priority over everything):
  - Count is cleared to 0 at the edge.
  - A same-cycle issue handshake is discarded.
  - A same-cycle grant is ignored; the unit does not re-broadcast.
  - intCDB_req=0 in the following cycle.
- grant without req: ignored.
- Pointer wrap: the 1-bit read/write pointers wrap 1->0.

## Timing
- Reset (rst high at an edge):
  - count=0, pointers=0.
  - Outputs next cycle: intCDB_req=0, intCDB_ROB_index=0, intCDB_data=0, intCDB_exc=0.
  - issue_ready=0 while rst is high, and 1 in the first cycle after rst falls.
- Reset mid-operation behaves identically to flush plus forcing the outputs to zero.
- Latency: issue accepted at edge N, so intCDB_req=1 with the result from cycle N+1. The minimum issue-to-broadcast time is 1 cycle.
- Throughput: 1 instruction/cycle while grants are continuous.

## Configuration
- ALU_OVERFLOW_EXC_EN
  - Defined:
    - ADD/SUB signed overflow sets the entry's exc bit. Overflow condition: operand signs equal (SUB: a and ~b) and the result sign differs.
    - The data is still the wrapped result.
    - The intCDB_exc port exists and the ROB marks the entry as excepting.
  - Undefined: the intCDB_exc port and its storage are removed, and overflow wraps silently.

## Test plan
- Reset then single ADD:
  - Stimulus: a=5, b=7, dest=3, grant held 1.
  - Response: req=1 one cycle after issue with index=3, data=12, then req=0 the next cycle.
- Backpressure:
  - Stimulus: issue 3 ops (ROB 1,2,3) back-to-back with grant=0.
  - Response: issue_ready=0 after the 2nd accept and the 3rd op is held. Raise grant: ROB 1, 2, 3 broadcast in order on consecutive cycles.
- Opcode sweep:
  - a=0x80000000, b=4: SRA gives 0xF8000000, SRL gives 0x08000000, SLT(a, 1) gives 1, SLTU(a, 1) gives 0.
  - LUI with imm=0x1234 and use_imm=1 gives 0x12340000.
  - LINK with pc=0x100 gives 0x108.
- Flush:
  - Stimulus: two entries buffered, flush asserted together with a new issue and grant.
  - Response: next cycle req=0, count=0, no broadcast of any of the three.
- Simultaneous push/pop:
  - Stimulus: count=1, issue ROB 9 in the same cycle the ROB 4 head is granted.
  - Response: count stays 1 and the head is ROB 9 next cycle.
- Overflow (macro on):
  - ADD 0x7FFFFFFF+1 gives data=0x80000000, exc=1.
  - SUB 0x80000000-1 gives exc=1.
  - ADD 1+1 gives exc=0.
  - With the macro off, the same data is produced and the port is absent.
